// File: rtl/ama_riscv_alu.sv
// AMA-RISCV RV32I execute-stage ALU.
// Combinational result plus a registered copy and an invalid-opcode flag.
module ama_riscv_alu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  op_sel,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [31:0] out_s,
    output logic [31:0] out_s_q,
    output logic        op_invalid
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_PASS = 4'b1111;

    logic        is_add;
    logic        is_sub;
    logic        is_sll;
    logic        is_srl;
    logic        is_sra;
    logic        is_slt;
    logic        is_sltu;
    logic        is_xor;
    logic        is_or;
    logic        is_and;
    logic        is_pass;

    logic [4:0]  shamt;
    logic [31:0] b_eff;
    logic [31:0] sum;
    logic [31:0] sll_r;
    logic [31:0] srl_r;
    logic [31:0] sra_r;
    logic        lt_s;
    logic        lt_u;

    assign is_add  = (op_sel == OP_ADD);
    assign is_sub  = (op_sel == OP_SUB);
    assign is_sll  = (op_sel == OP_SLL);
    assign is_srl  = (op_sel == OP_SRL);
    assign is_sra  = (op_sel == OP_SRA);
    assign is_slt  = (op_sel == OP_SLT);
    assign is_sltu = (op_sel == OP_SLTU);
    assign is_xor  = (op_sel == OP_XOR);
    assign is_or   = (op_sel == OP_OR);
    assign is_and  = (op_sel == OP_AND);
    assign is_pass = (op_sel == OP_PASS);

    // ADD and SUB share one adder: a + ~b + 1 for subtraction
    assign b_eff = is_sub ? ~in_b : in_b;
    assign sum   = in_a + b_eff + {31'd0, is_sub};

    assign shamt = in_b[4:0];
    assign sll_r = in_a << shamt;
    assign srl_r = in_a >> shamt;
    assign sra_r = $unsigned($signed(in_a) >>> shamt);

    assign lt_s = ($signed(in_a) < $signed(in_b));
    assign lt_u = (in_a < in_b);

    always_comb begin
        out_s      = 32'h0;
        op_invalid = 1'b0;
        unique case (1'b1)
            is_add,
            is_sub:  out_s = sum;
            is_sll:  out_s = sll_r;
            is_srl:  out_s = srl_r;
            is_sra:  out_s = sra_r;
            is_slt:  out_s = {31'd0, lt_s};
            is_sltu: out_s = {31'd0, lt_u};
            is_xor:  out_s = in_a ^ in_b;
            is_or:   out_s = in_a | in_b;
            is_and:  out_s = in_a & in_b;
            is_pass: out_s = in_b;
            default: begin
                out_s      = 32'h0;
                op_invalid = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_s_q <= 32'h0;
        end else begin
            out_s_q <= out_s;
        end
    end

endmodule

// File: tb/tb_ama_riscv_alu.sv
// Self-checking bench for ama_riscv_alu.
// Random and directed stimulus against a behavioural reference model.
module tb_ama_riscv_alu;

    logic        clk;
    logic        rst_n;
    logic [3:0]  op_sel;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] out_s;
    logic [31:0] out_s_q;
    logic        op_invalid;

    int errors = 0;
    int checks = 0;

    ama_riscv_alu dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op_sel     (op_sel),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_s      (out_s),
        .out_s_q    (out_s_q),
        .op_invalid (op_invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
    } vec_t;

    // returns {invalid, result}
    function automatic logic [32:0] ref_alu(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned sh;
        longint unsigned ext;
        logic [31:0] r;
        logic inv;
        sh  = int'(b % 32);
        r   = 32'h0;
        inv = 1'b0;
        case (op)
            4'b0000: r = 32'(longint'(a) + longint'(b));
            4'b1000: r = 32'(longint'(a) - longint'(b));
            4'b0001: r = 32'(64'(a) * (64'd1 << sh));
            4'b0101: r = 32'(64'(a) / (64'd1 << sh));
            4'b1101: begin
                ext = a[31] ? {32'hFFFFFFFF, a} : {32'h0, a};
                r = 32'(ext >> sh);
            end
            4'b0010: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'b0011: r = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
            4'b0100: r = a ^ b;
            4'b0110: r = a | b;
            4'b0111: r = a & b;
            4'b1111: r = b;
            default: inv = 1'b1;
        endcase
        return {inv, r};
    endfunction

    task automatic test_reset();
        rst_n  = 1'b0;
        op_sel = 4'b0000;
        in_a   = 32'd5;
        in_b   = 32'd6;
        @(posedge clk);
        #1;
        checks++;
        if (out_s_q !== 32'h0) begin
            errors++;
            $display("FAIL reset_q: got %h exp %h", out_s_q, 32'h0);
        end
        checks++;
        if (out_s !== 32'd11) begin
            errors++;
            $display("FAIL reset_comb: got %h exp %h", out_s, 32'd11);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        vec_t v[$];
        v.push_back({4'b0000, 32'd16, 32'd11, 32'd27});
        v.push_back({4'b1000, 32'd17, 32'd10, 32'd7});
        v.push_back({4'b1111, 32'd35, 32'd192, 32'd192});
        v.push_back({4'b1101, 32'd35, 32'd4, 32'd2});
        v.push_back({4'b0101, 32'd35, 32'd4, 32'd2});
        v.push_back({4'b0001, 32'd35, 32'd4, 32'd560});
        v.push_back({4'b1101, 32'h80000000, 32'd4, 32'hF8000000});
        v.push_back({4'b0101, 32'h80000000, 32'd4, 32'h08000000});
        v.push_back({4'b0001, 32'd1, 32'h24, 32'h10});
        v.push_back({4'b0001, 32'hDEADBEEF, 32'd0, 32'hDEADBEEF});
        v.push_back({4'b1101, 32'h80000001, 32'd0, 32'h80000001});
        v.push_back({4'b0101, 32'h80000001, 32'hFFFFFFE0, 32'h80000001});
        v.push_back({4'b1101, 32'h80000000, 32'd31, 32'hFFFFFFFF});
        v.push_back({4'b0010, 32'hFFFFFFFF, 32'd1, 32'd1});
        v.push_back({4'b0011, 32'hFFFFFFFF, 32'd1, 32'd0});
        v.push_back({4'b0010, 32'd5, 32'd5, 32'd0});
        v.push_back({4'b0011, 32'd5, 32'd5, 32'd0});
        v.push_back({4'b0011, 32'd1, 32'hFFFFFFFF, 32'd1});
        v.push_back({4'b0000, 32'hFFFFFFFF, 32'd1, 32'd0});
        v.push_back({4'b1000, 32'd0, 32'd1, 32'hFFFFFFFF});
        v.push_back({4'b0100, 32'hF0F0FFFF, 32'h0FF0F000, 32'hFF000FFF});
        v.push_back({4'b0110, 32'hF0000000, 32'h0000000F, 32'hF000000F});
        v.push_back({4'b0111, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000});
        foreach (v[i]) begin
            op_sel = v[i].op;
            in_a   = v[i].a;
            in_b   = v[i].b;
            #1;
            checks++;
            if (out_s !== v[i].e) begin
                errors++;
                $display("FAIL dir%0d op=%b: got %h exp %h",
                         i, v[i].op, out_s, v[i].e);
            end
            checks++;
            if (op_invalid !== 1'b0) begin
                errors++;
                $display("FAIL dir%0d_inv: got %b exp 0", i, op_invalid);
            end
        end
    endtask

    task automatic test_invalid();
        logic [3:0] bad [5];
        bad = '{4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1110};
        foreach (bad[i]) begin
            op_sel = bad[i];
            in_a   = 32'h12345678;
            in_b   = 32'h9ABCDEF0;
            #1;
            checks++;
            if (out_s !== 32'h0 || op_invalid !== 1'b1) begin
                errors++;
                $display("FAIL invalid op=%b: got %h/%b exp 0/1",
                         bad[i], out_s, op_invalid);
            end
        end
    endtask

    task automatic test_random();
        logic [32:0] exp;
        for (int i = 0; i < 96; i++) begin
            op_sel = 4'($urandom_range(0, 15));
            in_a   = $urandom;
            in_b   = (i % 4 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            exp    = ref_alu(op_sel, in_a, in_b);
            #1;
            checks++;
            if (out_s !== exp[31:0] || op_invalid !== exp[32]) begin
                errors++;
                $display("FAIL rand%0d op=%b a=%h b=%h: got %h/%b exp %h/%b",
                         i, op_sel, in_a, in_b, out_s, op_invalid,
                         exp[31:0], exp[32]);
            end
        end
    endtask

    task automatic test_register();
        @(negedge clk);
        op_sel = 4'b0000;
        in_a   = 32'd16;
        in_b   = 32'd11;
        @(posedge clk);
        #1;
        checks++;
        if (out_s_q !== 32'd27) begin
            errors++;
            $display("FAIL reg_add: got %h exp %h", out_s_q, 32'd27);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_s_q !== 32'h0) begin
            errors++;
            $display("FAIL async_rst: got %h exp 0", out_s_q);
        end
        checks++;
        if (out_s !== 32'd27) begin
            errors++;
            $display("FAIL rst_comb: got %h exp %h", out_s, 32'd27);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        op_sel = 4'b1000;
        in_a   = 32'd17;
        in_b   = 32'd10;
        @(posedge clk);
        #1;
        checks++;
        if (out_s_q !== 32'd7) begin
            errors++;
            $display("FAIL rst_release: got %h exp %h", out_s_q, 32'd7);
        end
    endtask

    task automatic test_back_to_back();
        logic [32:0] exp;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            op_sel = 4'($urandom_range(0, 15));
            in_a   = $urandom;
            in_b   = $urandom;
            #2;
            op_sel = 4'($urandom_range(0, 15));
            in_a   = $urandom;
            in_b   = $urandom;
            exp    = ref_alu(op_sel, in_a, in_b);
            @(posedge clk);
            #1;
            checks++;
            if (out_s_q !== exp[31:0]) begin
                errors++;
                $display("FAIL b2b%0d: got %h exp %h", i, out_s_q, exp[31:0]);
            end
            op_sel = ~op_sel;
            in_a   = ~in_a;
            #2;
            checks++;
            if (out_s_q !== exp[31:0]) begin
                errors++;
                $display("FAIL b2b_hold%0d: got %h exp %h",
                         i, out_s_q, exp[31:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_invalid();
        test_random();
        test_register();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
